// File: rtl/usb_uart_tx_sched.sv
// Shares the USB-UART transmit register path among NumReq byte-stream requesters.
// Latency: 5 cycles per byte when the peripheral is idle. Arbitration is round-robin per packet.
// Backpressure: each busy poll that reads 1 adds two cycles; a requester is stalled until its one-cycle ready pulse.
//
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   req_valid_i/data/last       per-requester byte stream (8 bits per requester, packed)
//   req_ready_o                 one-cycle accept pulse to the lock owner
//   bus_address_o/data_o/rd_wr_o, bus_data_i   peripheral register bus (read data registered)
//   grant_o, busy_o, lock_timeout_o, bytes_sent_o   status
module usb_uart_tx_sched #(
  parameter int          NumReq      = 2,
  parameter logic [15:0] UartBase    = 16'h0000,
  parameter int          LockTimeout = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [NumReq-1:0]     req_valid_i,
  input  logic [8*NumReq-1:0]   req_data_i,
  input  logic [NumReq-1:0]     req_last_i,
  output logic [NumReq-1:0]     req_ready_o,
  output logic [15:0]           bus_address_o,
  output logic [7:0]            bus_data_o,
  output logic                  bus_rd_wr_o,
  input  logic [7:0]            bus_data_i,
  output logic [NumReq-1:0]     grant_o,
  output logic                  busy_o,
  output logic                  lock_timeout_o,
  output logic [15:0]           bytes_sent_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(LockTimeout + 1);

  // Offsets +3/+4 are never generated: reading +3 would pop the RX FIFO.
  localparam logic [15:0] AddrData = UartBase;
  localparam logic [15:0] AddrSend = UartBase + 16'd1;
  localparam logic [15:0] AddrBusy = UartBase + 16'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POLL_A = 3'd1,
    POLL_D = 3'd2,
    WR_D   = 3'd3,
    WR_S   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              lock_vld_q, lock_vld_d;
  logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [CntW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [15:0]       bytes_sent_q;
  logic              bytes_inc;

  // View of the lock owner's stream.
  logic              cur_vld;
  logic              cur_last;
  logic [7:0]        cur_dat;
  logic [IdxW-1:0]   rr_after_owner;

  always_comb begin
    cur_vld  = 1'b0;
    cur_last = 1'b0;
    cur_dat  = 8'h00;
    for (int k = 0; k < NumReq; k++) begin
      if (lock_idx_q == IdxW'(k)) begin
        cur_vld  = req_valid_i[k];
        cur_last = req_last_i[k];
        cur_dat  = req_data_i[8*k +: 8];
      end
    end
  end

  // The pointer moves just past the owner whenever a lock is released.
  assign rr_after_owner = (lock_idx_q == IdxW'(NumReq - 1)) ? '0 : lock_idx_q + 1'b1;

  // Round-robin search starting at rr_q, wrapping at NumReq.
  logic            pick_vld;
  logic [IdxW-1:0] pick_idx;

  always_comb begin
    int j;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      j = int'(rr_q) + i;
      if (j >= NumReq) j = j - NumReq;
      for (int k = 0; k < NumReq; k++) begin
        if (!pick_vld && (j == k) && req_valid_i[k]) begin
          pick_vld = 1'b1;
          pick_idx = IdxW'(k);
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    lock_vld_d     = lock_vld_q;
    lock_idx_d     = lock_idx_q;
    rr_d           = rr_q;
    idle_cnt_d     = '0;
    bytes_inc      = 1'b0;
    req_ready_o    = '0;
    bus_address_o  = AddrBusy;
    bus_data_o     = 8'h00;
    bus_rd_wr_o    = 1'b0;
    lock_timeout_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (!lock_vld_q) begin
          if (pick_vld) begin
            lock_vld_d = 1'b1;
            lock_idx_d = pick_idx;
            state_d    = POLL_A;
          end
        end else if (cur_vld) begin
          state_d = POLL_A;
        end else if (idle_cnt_q == CntW'(LockTimeout - 1)) begin
          // The owner stalled mid-packet too long; let others in.
          lock_vld_d     = 1'b0;
          lock_timeout_o = 1'b1;
          rr_d           = rr_after_owner;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      POLL_A: begin
        state_d = POLL_D;
      end
      POLL_D: begin
        // Read data returned for the address presented in POLL_A.
        state_d = bus_data_i[0] ? POLL_A : WR_D;
      end
      WR_D: begin
        bus_address_o = AddrData;
        bus_data_o    = cur_dat;
        bus_rd_wr_o   = 1'b1;
        state_d       = WR_S;
      end
      WR_S: begin
        bus_address_o = AddrSend;
        bus_rd_wr_o   = 1'b1;
        bytes_inc     = 1'b1;
        for (int k = 0; k < NumReq; k++) begin
          if (lock_idx_q == IdxW'(k)) req_ready_o[k] = 1'b1;
        end
        if (cur_last) begin
          lock_vld_d = 1'b0;
          rr_d       = rr_after_owner;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      lock_vld_q   <= 1'b0;
      lock_idx_q   <= '0;
      rr_q         <= '0;
      idle_cnt_q   <= '0;
      bytes_sent_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
      idle_cnt_q <= idle_cnt_d;
      if (bytes_inc) bytes_sent_q <= bytes_sent_q + 16'd1;
    end
  end

  always_comb begin
    grant_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (lock_vld_q && (lock_idx_q == IdxW'(k))) grant_o[k] = 1'b1;
    end
  end

  assign busy_o       = (state_q != IDLE) || lock_vld_q;
  assign bytes_sent_o = bytes_sent_q;

endmodule

// File: tb/tb_usb_uart_tx_sched.sv
// Scoreboard bench for usb_uart_tx_sched: directed packets, registered peripheral model.
// Expected sends are queued as {requester, byte}; a negedge monitor pops one per send strobe.
// Requester drivers hold valid/data/last until their ready pulse.
module tb_usb_uart_tx_sched;

  localparam int          NR   = 2;
  localparam logic [15:0] BASE = 16'h0000;
  localparam logic [15:0] A_DATA = BASE;
  localparam logic [15:0] A_SEND = BASE + 16'd1;
  localparam logic [15:0] A_BUSY = BASE + 16'd2;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic [NR-1:0]     req_valid_i;
  logic [8*NR-1:0]   req_data_i;
  logic [NR-1:0]     req_last_i;
  logic [NR-1:0]     req_ready_o;
  logic [15:0]       bus_address_o;
  logic [7:0]        bus_data_o;
  logic              bus_rd_wr_o;
  logic [7:0]        bus_data_i = 8'h00;
  logic [NR-1:0]     grant_o;
  logic              busy_o;
  logic              lock_timeout_o;
  logic [15:0]       bytes_sent_o;

  usb_uart_tx_sched #(.NumReq(NR), .UartBase(BASE), .LockTimeout(255)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o),
    .bus_address_o(bus_address_o), .bus_data_o(bus_data_o), .bus_rd_wr_o(bus_rd_wr_o),
    .bus_data_i(bus_data_i),
    .grant_o(grant_o), .busy_o(busy_o), .lock_timeout_o(lock_timeout_o),
    .bytes_sent_o(bytes_sent_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Peripheral: busy register read data appears the cycle after the address.
  logic periph_busy = 1'b0;
  always @(posedge clk_i)
    bus_data_i <= (!bus_rd_wr_o && bus_address_o == A_BUSY) ? {7'b0, periph_busy} : 8'h00;

  // Per-requester stimulus queues: {last, data}.
  logic [8:0]  rq [NR][$];
  logic [11:0] exp_q [$];   // {requester index, byte}

  for (genvar g = 0; g < NR; g++) begin : drv
    logic       v = 1'b0;
    logic [7:0] d = 8'h00;
    logic       l = 1'b0;
    assign req_valid_i[g]        = v;
    assign req_data_i[8*g +: 8]  = d;
    assign req_last_i[g]         = l;
    initial begin
      forever begin
        @(negedge clk_i);
        if (v && req_ready_o[g]) begin
          void'(rq[g].pop_front());
          @(posedge clk_i);
          #1;
          v = 1'b0; d = 8'h00; l = 1'b0;
          if (rq[g].size() > 0) begin
            {l, d} = rq[g][0];
            v = 1'b1;
          end
        end else if (!v && rq[g].size() > 0) begin
          {l, d} = rq[g][0];
          v = 1'b1;
        end
      end
    end
  end

  // Monitor-side counters.
  int mon_chk = 0, mon_pass = 0;
  int data_wr_cnt = 0, send_cnt = 0, tmo_cnt = 0, addr_bad = 0;
  int last_send_cyc = 0, tmo_cyc = 0;
  int send_cyc_q [$];
  logic [7:0]  data_seen;
  logic        data_have = 1'b0;
  logic [15:0] prev_addr = A_BUSY;
  logic        prev_wr = 1'b0;

  task automatic mon_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    mon_chk++;
    if (act === exp) mon_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk_i) begin
    logic [3:0]  ridx;
    logic [11:0] e;
    if (!reset_n_i) begin
      data_have = 1'b0;
      prev_addr = A_BUSY;
      prev_wr   = 1'b0;
    end else begin
      if (bus_address_o == BASE + 16'd3 || bus_address_o == BASE + 16'd4) addr_bad++;
      if (req_ready_o != '0) mon_check("ready_onehot", 32'($countones(req_ready_o)), 32'd1);
      if (lock_timeout_o) begin
        tmo_cnt++;
        tmo_cyc = cyc;
      end
      if (bus_rd_wr_o && bus_address_o == A_DATA) begin
        mon_check("data_wr_after_poll", 32'({prev_wr, prev_addr}), 32'({1'b0, A_BUSY}));
        data_seen = bus_data_o;
        data_have = 1'b1;
        data_wr_cnt++;
      end
      if (bus_rd_wr_o && bus_address_o == A_SEND) begin
        mon_check("send_after_data_wr", 32'({prev_wr, prev_addr, data_have}), 32'({1'b1, A_DATA, 1'b1}));
        ridx = 4'hF;
        for (int k = 0; k < NR; k++) if (req_ready_o[k]) ridx = 4'(k);
        if (exp_q.size() == 0) begin
          mon_check("unexpected_send", 32'({ridx, data_seen}), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          mon_check("send_req_byte", 32'({ridx, data_seen}), 32'(e));
        end
        data_have = 1'b0;
        send_cnt++;
        last_send_cyc = cyc;
        send_cyc_q.push_back(cyc);
      end
      prev_addr = bus_address_o;
      prev_wr   = bus_rd_wr_o;
    end
  end

  // Test-side counters.
  int tst_chk = 0, tst_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tst_chk++;
    if (act === exp) tst_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int r, input logic last, input logic [7:0] b);
    rq[r].push_back({last, b});
    exp_q.push_back({4'(r), b});
  endtask

  task automatic drain(input string name, input int max_cyc);
    bool_done: begin
      for (int n = 0; n < max_cyc; n++) begin
        @(posedge clk_i);
        #1;
        if (exp_q.size() == 0 && rq[0].size() == 0 && rq[1].size() == 0 && req_valid_i == '0)
          disable bool_done;
      end
      check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    int base, tsend, found;
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_addr", 32'(bus_address_o), 32'(A_BUSY));
    check("rst_rdwr", 32'(bus_rd_wr_o), 32'd0);
    check("rst_data", 32'(bus_data_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_tmo", 32'(lock_timeout_o), 32'd0);
    check("rst_bytes", 32'(bytes_sent_o), 32'd0);

    // Single byte.
    push(0, 1'b1, 8'h41);
    drain("single", 100);
    check("single_bytes", 32'(bytes_sent_o), 32'd1);
    check("single_grant", 32'(grant_o), 32'd0);
    check("single_busy", 32'(busy_o), 32'd0);

    // Round robin from a fresh pointer.
    do_reset();
    send_cyc_q.delete();
    push(0, 1'b0, 8'hA0); push(0, 1'b1, 8'hA1);
    push(1, 1'b0, 8'hB0); push(1, 1'b1, 8'hB1);
    drain("rr", 200);
    check("rr_nsends", 32'(send_cyc_q.size()), 32'd4);
    for (int i = 1; i < 4; i++)
      if (send_cyc_q.size() == 4)
        check("rr_spacing", 32'(send_cyc_q[i] - send_cyc_q[i-1]), 32'd5);
    push(1, 1'b1, 8'hC0);
    drain("rr_solo", 100);
    push(0, 1'b1, 8'hD0);
    push(1, 1'b1, 8'hE0);
    drain("rr_contest", 100);

    // Busy back-pressure.
    periph_busy = 1'b1;
    base = data_wr_cnt;
    push(0, 1'b1, 8'h77);
    repeat (40) @(posedge clk_i);
    #1;
    check("busy_no_write", 32'(data_wr_cnt - base), 32'd0);
    check("busy_locked", 32'(busy_o), 32'd1);
    periph_busy = 1'b0;
    drain("busy", 100);
    check("busy_one_write", 32'(data_wr_cnt - base), 32'd1);

    // Lock timeout.
    base = tmo_cnt;
    push(0, 1'b0, 8'h10);
    drain("tmo_first", 100);
    tsend = last_send_cyc;
    check("tmo_grant_held", 32'(grant_o), 32'd1);
    push(1, 1'b1, 8'h20);
    drain("tmo_second", 400);
    check("tmo_pulses", 32'(tmo_cnt - base), 32'd1);
    check("tmo_delay", 32'(tmo_cyc - tsend), 32'd255);
    check("tmo_next_send", 32'(last_send_cyc - tmo_cyc), 32'd5);
    check("tmo_grant", 32'(grant_o), 32'd0);

    // Reset while the data register write is on the bus.
    do_reset();
    push(0, 1'b1, 8'h55);
    found = 0;
    for (int n = 0; n < 50 && found == 0; n++) begin
      @(negedge clk_i);
      if (bus_rd_wr_o && bus_address_o == A_DATA) found = 1;
    end
    check("midrst_wr_d_seen", 32'(found), 32'd1);
    reset_n_i = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready_o), 32'd0);
    check("midrst_addr", 32'({bus_rd_wr_o, bus_address_o}), 32'({1'b0, A_BUSY}));
    check("midrst_grant", 32'(grant_o), 32'd0);
    check("midrst_bytes", 32'(bytes_sent_o), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    drain("midrst", 100);
    check("midrst_sent_once", 32'(bytes_sent_o), 32'd1);

    // Counter wrap from a preloaded value.
    @(negedge clk_i);
    force dut.bytes_sent_q = 16'hFFFE;
    @(negedge clk_i);
    release dut.bytes_sent_q;
    #1;
    check("wrap_preload", 32'(bytes_sent_o), 32'hFFFE);
    push(0, 1'b1, 8'h01);
    push(0, 1'b1, 8'h02);
    drain("wrap", 100);
    check("wrap_zero", 32'(bytes_sent_o), 32'd0);

    check("addr_never_3_4", 32'(addr_bad), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", tst_pass + mon_pass, tst_chk + mon_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/usb_uart_tx_sched.md
Name: usb_uart_tx_sched

Overview:
- Bus-master scheduler that shares the USB-UART peripheral's transmit path among NumReq byte-stream requesters (CPU log path, debug streamer, etc.).
- Arbitrates per packet with round-robin fairness.
- Drives the peripheral register interface in a fixed sequence per byte: poll busy, write the data register, write the send strobe.
- Sits on the 16-bit address / 8-bit data bus, between the requesters and the peripheral.

Parameters:
- NumReq, 2, number of requesters; legal range 1..8.
- UartBase, 0, peripheral base address. Used offsets: +0 data, +1 send, +2 busy.
- LockTimeout, 255, cycles a locked requester may hold valid low mid-packet before its lock is dropped.

Ports:
- clk_i  in  1  system clock
- reset_n_i  in  1  asynchronous, active-low reset
- req_valid_i  in  NumReq  per-requester byte valid
- req_data_i  in  8*NumReq  byte for requester k at bits [8k+7:8k]
- req_last_i  in  NumReq  byte is the last of its packet
- req_ready_o  out  NumReq  one-cycle accept pulse
- bus_address_o  out  16  peripheral address
- bus_data_o  out  8  peripheral write data
- bus_rd_wr_o  out  1  1 = write, 0 = read
- bus_data_i  in  8  peripheral registered read data, valid the cycle after the address is presented
- grant_o  out  NumReq  one-hot lock owner; 0 when unlocked
- busy_o  out  1  high when state is not IDLE or a lock is held
- lock_timeout_o  out  1  one-cycle pulse when a lock is dropped by timeout
- bytes_sent_o  out  16  count of bytes sent, wraps at 65535 -> 0

Behaviour:
- Reset (async assert, sync release) returns:
  - state IDLE, no lock, rr pointer 0;
  - all outputs 0 except bus_address_o = UartBase+2.
- Bus idle value, driven in every state that is not accessing the peripheral: address UartBase+2, rd_wr 0, data 0.
- The block never presents UartBase+3 or UartBase+4, because reading +3 pops the peripheral's RX FIFO.
- IDLE:
  - Unlocked: pick the first k with req_valid_i[k]=1, searching from rr pointer upward with wrap. Set lock to k, grant_o[k]=1, go POLL_A.
  - Locked to k with req_valid_i[k]=1: go POLL_A.
  - Locked with valid low: increment the idle counter. When the counter reaches LockTimeout, clear the lock, pulse lock_timeout_o, and set rr = k+1 mod NumReq.
- POLL_A: drive UartBase+2, rd_wr 0. Next state POLL_D.
- POLL_D: sample bus_data_i[0].
  - If 1 (TX FIFO almost full), return to POLL_A. There is no poll limit.
  - If 0, go WR_D.
- WR_D: drive address UartBase+0, data req_data_i[k], rd_wr 1. Next state WR_S.
- WR_S: drive UartBase+1, rd_wr 1; pulse req_ready_o[k]; increment bytes_sent_o.
  - If req_last_i[k]=1: clear the lock, set rr = k+1 mod NumReq, go IDLE.
  - Otherwise keep the lock and go IDLE.
- Minimum cost is 5 cycles per byte (IDLE, POLL_A, POLL_D, WR_D, WR_S) when the peripheral is not busy.
- Requester rules:
  - Once valid is high, data and last hold until ready.
  - Data and last are sampled in both WR_D and WR_S; they must match.
  - Dropping valid without ready is a protocol violation; behaviour is undefined.
- The idle counter clears on any cycle where the locked requester's valid is high, and whenever the lock changes.
- Only one req_ready_o bit is ever high. grant_o changes only in IDLE or WR_S.
- Reset asserted between WR_D and WR_S: the byte sits in the peripheral data register but is never sent, and no ready is issued. The requester still holds valid, so the byte is re-sent after reset. No byte is lost or duplicated.
- NumReq=1: arbitration degenerates; rr stays 0.

Test Plan:
- Single byte: req 0 sends 0x41 with last=1 and busy=0 -> bus sequence +2 read, +0 write 0x41, +1 write; req_ready_o[0] pulses in cycle 5; bytes_sent_o=1; grant_o=0.
- Round-robin: both requesters hold 2-byte packets (0xA0,0xA1 / 0xB0,0xB1) -> wire order A0 A1 B0 B1; next contest is won by req 1 only if req 0 is idle, otherwise by req 0.
- Busy back-pressure: bus_data_i=0x01 for 10 polls, then 0x00 -> 10 POLL_A/POLL_D pairs, then a single +0/+1 write pair; no write occurs while busy.
- Lock timeout: req 0 sends a byte with last=0, then drops valid; req 1 is valid -> after 255 cycles lock_timeout_o pulses once, and req 1's byte is the next written.
- Reset mid-transfer: assert reset_n_i during WR_D with byte 0x55 -> no ready, outputs return to reset values; after release 0x55 is written and sent exactly once.
- Counter wrap: preload by sending 65536 bytes -> bytes_sent_o reads 0; an address check throughout confirms UartBase+3 and +4 never appear.
